// File: rtl/onehot_dec3to8_seq.sv
// rtl/onehot_dec3to8_seq.sv - buffered 3-to-8 decoder holding each one-hot code for HOLD_CYCLES
module onehot_dec3to8_seq #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic [7:0] out_y,
  output logic       out_valid,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [2:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_y_q, out_y_d;
  logic             out_valid_q, out_valid_d;
  logic             empty, full, push, pop;
  logic [2:0]       head;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign busy     = (state_q == S_HOLD) || !empty;

  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en && !empty) state_d = S_HOLD;
      S_HOLD: begin
        if (!en)                           state_d = S_IDLE;
        else if ((cnt_q == '0) && empty)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pop decisions use only registered pointers, so a freshly pushed code waits one edge.
  always_comb begin
    pop         = 1'b0;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (en && !empty) begin
          pop         = 1'b1;
          out_y_d     = 8'd1 << head;
          out_valid_d = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (!en) begin
          out_y_d     = '0;
          out_valid_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!empty) begin
          pop         = 1'b1;
          out_y_d     = 8'd1 << head;
          out_valid_d = 1'b1;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          out_y_d     = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_y_d     = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_dec3to8_seq.sv
// tb/tb_onehot_dec3to8_seq.sv - directed checks of onehot_dec3to8_seq (HOLD_CYCLES 4 and 1)
module tb_onehot_dec3to8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, vld0, rdy0, ov0, busy0;
  logic [2:0] code0;
  logic [7:0] y0;
  logic       en1, vld1, rdy1, ov1, busy1;
  logic [2:0] code1;
  logic [7:0] y1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  onehot_dec3to8_seq #(.DEPTH(4), .HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst(rst), .en(en0), .in_valid(vld0), .in_ready(rdy0),
    .in_code(code0), .out_y(y0), .out_valid(ov0), .busy(busy0)
  );

  onehot_dec3to8_seq #(.DEPTH(4), .HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .en(en1), .in_valid(vld1), .in_ready(rdy1),
    .in_code(code1), .out_y(y1), .out_valid(ov1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_y;
    logic [2:0] q_codes [4];

    rst = 1'b1; en0 = 1'b0; vld0 = 1'b0; code0 = '0;
    en1 = 1'b0; vld1 = 1'b0; code1 = '0;
    tick();
    tick();
    chk("rst_out_y", y0, 8'h00);
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_in_ready", rdy0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", rdy0, 1'b1);

    // single code 3
    en0 = 1'b1; vld0 = 1'b1; code0 = 3'd3;
    tick();
    vld0 = 1'b0;
    chk("t1_no_bypass", y0, 8'h00);
    chk("t1_busy_queued", busy0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_hold_y", y0, 8'h08);
      chk("t1_hold_valid", ov0, 1'b1);
    end
    tick();
    chk("t1_end_y", y0, 8'h00);
    chk("t1_end_valid", ov0, 1'b0);
    chk("t1_end_busy", busy0, 1'b0);

    // back-to-back 7, 0, 5
    for (int k = 0; k < 14; k++) begin
      vld0 = (k < 3);
      code0 = (k == 0) ? 3'd7 : (k == 1) ? 3'd0 : 3'd5;
      tick();
      if (k == 0 || k == 13)  exp_y = 8'h00;
      else if (k <= 4)        exp_y = 8'h80;
      else if (k <= 8)        exp_y = 8'h01;
      else                    exp_y = 8'h20;
      chk("t2_b2b_y", y0, exp_y);
      chk("t2_b2b_valid", ov0, exp_y != 8'h00);
    end
    vld0 = 1'b0;

    // fill with en=0, then drain
    en0 = 1'b0;
    q_codes[0] = 3'd1; q_codes[1] = 3'd2; q_codes[2] = 3'd3; q_codes[3] = 3'd4;
    for (int k = 0; k < 4; k++) begin
      vld0 = 1'b1; code0 = q_codes[k];
      tick();
    end
    chk("t3_full_ready", rdy0, 1'b0);
    chk("t3_full_y", y0, 8'h00);
    code0 = 3'd6;
    tick();
    chk("t3_5th_ready", rdy0, 1'b0);
    vld0 = 1'b0; en0 = 1'b1;
    tick();
    chk("t3_ready_after_pop", rdy0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      exp_y = 8'd1 << q_codes[k / 4];
      chk("t3_drain_y", y0, exp_y);
    end
    tick();
    chk("t3_drain_end", y0, 8'h00);
    chk("t3_drain_busy", busy0, 1'b0);

    // abort code 6 after 2 cycles, code 2 queued
    vld0 = 1'b1; code0 = 3'd6;
    tick();
    code0 = 3'd2;
    tick();
    vld0 = 1'b0;
    chk("t4_hold6_a", y0, 8'h40);
    tick();
    chk("t4_hold6_b", y0, 8'h40);
    en0 = 1'b0;
    tick();
    chk("t4_abort_y", y0, 8'h00);
    chk("t4_abort_valid", ov0, 1'b0);
    chk("t4_abort_busy", busy0, 1'b1);
    en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_code2_y", y0, 8'h04);
    end
    tick();
    chk("t4_no_reemit", y0, 8'h00);
    tick();
    chk("t4_no_reemit2", y0, 8'h00);

    // HOLD_CYCLES=1 stream 0..7
    en1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vld1 = (k < 8);
      code1 = 3'(k);
      tick();
      exp_y = (k == 0 || k == 9) ? 8'h00 : (8'd1 << (k - 1));
      chk("t5_stream_y", y1, exp_y);
      chk("t5_stream_ready", rdy1, 1'b1);
    end
    vld1 = 1'b0;

    // reset during HOLD with two codes queued
    for (int k = 0; k < 3; k++) begin
      vld0 = 1'b1; code0 = 3'(k + 1);
      tick();
    end
    vld0 = 1'b0;
    chk("t6_pre_rst_y", y0, 8'h02);
    chk("t6_pre_rst_busy", busy0, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_rst_y", y0, 8'h00);
    chk("t6_rst_valid", ov0, 1'b0);
    chk("t6_rst_busy", busy0, 1'b0);
    chk("t6_rst_ready", rdy0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_discarded_y", y0, 8'h00);
    end
    chk("t6_final_busy", busy0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
